// File: rtl/nf10_crypto_pkt_buffer.sv
// Store-and-forward AXI4-Stream packet buffer.
// Beats are always accepted. A packet becomes visible to the read side only
// after its tlast beat is stored. A packet that hits a full buffer is dropped
// whole, so downstream never sees a truncated packet.
module nf10_crypto_pkt_buffer #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DEPTH_BITS         = 9
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [31:0]                       pkt_count,
  output logic [31:0]                       drop_count
);

  localparam int DEPTH  = 1 << C_DEPTH_BITS;
  localparam int WORD_W = 1 + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_DATA_WIDTH;

  // Pointer constants: one extra MSB tells full from empty after wrap.
  localparam logic [C_DEPTH_BITS:0] PTR_ONE  = {{C_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [C_DEPTH_BITS:0] FULL_OCC = {1'b1, {C_DEPTH_BITS{1'b0}}};

  typedef enum logic [0:0] {WRITE = 1'b0, DROP = 1'b1} wr_state_t;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [C_DEPTH_BITS:0] wr_cur;
  logic [C_DEPTH_BITS:0] wr_commit;
  logic [C_DEPTH_BITS:0] rd_ptr;
  logic [C_DEPTH_BITS:0] occupancy;
  wr_state_t             state;
  wr_state_t             state_next;

  logic accept;
  logic full;
  logic do_store;
  logic do_commit;
  logic do_rewind;
  logic do_drop;
  logic readable;
  logic do_load;

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign occupancy = wr_cur - rd_ptr;
  assign full      = (occupancy == FULL_OCC);
  assign readable  = (rd_ptr != wr_commit);
  assign do_load   = readable & (~m_axis_tvalid | m_axis_tready);

  // Write FSM next-state and per-beat store/commit/drop decisions.
  always_comb begin
    state_next = state;
    do_store   = 1'b0;
    do_commit  = 1'b0;
    do_rewind  = 1'b0;
    do_drop    = 1'b0;
    case (state)
      WRITE: begin
        if (accept) begin
          if (!full) begin
            do_store  = 1'b1;
            do_commit = s_axis_tlast;
          end else begin
            // No room: discard everything of this packet written so far.
            do_rewind = 1'b1;
            if (s_axis_tlast) begin
              do_drop = 1'b1;
            end else begin
              state_next = DROP;
            end
          end
        end else begin
          state_next = WRITE;
        end
      end
      DROP: begin
        if (accept && s_axis_tlast) begin
          do_drop    = 1'b1;
          state_next = WRITE;
        end else begin
          state_next = DROP;
        end
      end
      default: state_next = WRITE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= WRITE;
    end else begin
      state <= state_next;
    end
  end

  // Storage array; contents are only meaningful between rd_ptr and wr_cur.
  always_ff @(posedge s_axi_aclk) begin
    if (do_store) begin
      mem[wr_cur[C_DEPTH_BITS-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
    end
  end

  // Input ready, write pointers and packet counters.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      s_axis_tready <= 1'b0;
      wr_cur        <= '0;
      wr_commit     <= '0;
      pkt_count     <= 32'd0;
      drop_count    <= 32'd0;
    end else begin
      s_axis_tready <= 1'b1;
      if (do_store) begin
        wr_cur <= wr_cur + PTR_ONE;
      end else if (do_rewind) begin
        wr_cur <= wr_commit;
      end
      if (do_commit) begin
        wr_commit <= wr_cur + PTR_ONE;
        pkt_count <= pkt_count + 32'd1;
      end
      if (do_drop) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end

  // Output register and read pointer; holds data while stalled downstream.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tdata  <= '0;
    end else if (do_load) begin
      {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} <= mem[rd_ptr[C_DEPTH_BITS-1:0]];
      m_axis_tvalid <= 1'b1;
      rd_ptr        <= rd_ptr + PTR_ONE;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nf10_crypto_pkt_buffer.sv
// Bench for nf10_crypto_pkt_buffer: a default-depth instance and a 16-deep
// instance share the input stimulus; one of them is watched at a time.
module tb_nf10_crypto_pkt_buffer;

  typedef struct packed {
    logic         last;
    logic [127:0] user;
    logic [31:0]  strb;
    logic [255:0] data;
  } beat_t;

  typedef struct {
    int len1;
    int gap;
    int len2;
    bit keep1;
    bit keep2;
    int exp_pkt;
    int exp_drop;
  } scen_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tstrb = '0;
  logic [127:0] s_tuser = '0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic m_tready = 1'b0;

  logic big_s_tready, big_valid, big_last;
  logic [255:0] big_data;
  logic [31:0]  big_strb, big_pkt, big_drop;
  logic [127:0] big_user;
  logic sml_s_tready, sml_valid, sml_last;
  logic [255:0] sml_data;
  logic [31:0]  sml_strb, sml_pkt, sml_drop;
  logic [127:0] sml_user;

  logic use_small = 1'b0;
  logic mon_s_tready, mon_valid, mon_last;
  logic [255:0] mon_data;
  logic [31:0]  mon_strb, mon_pkt, mon_drop;
  logic [127:0] mon_user;

  assign mon_s_tready = use_small ? sml_s_tready : big_s_tready;
  assign mon_valid    = use_small ? sml_valid    : big_valid;
  assign mon_last     = use_small ? sml_last     : big_last;
  assign mon_data     = use_small ? sml_data     : big_data;
  assign mon_strb     = use_small ? sml_strb     : big_strb;
  assign mon_user     = use_small ? sml_user     : big_user;
  assign mon_pkt      = use_small ? sml_pkt      : big_pkt;
  assign mon_drop     = use_small ? sml_drop     : big_drop;

  int  errors = 0;
  int  checks = 0;
  bit  toggle_mode = 1'b0;
  beat_t exp_q[$];
  scen_t tbl[5];

  always #5 clk = ~clk;

  nf10_crypto_pkt_buffer u_big (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(big_s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(big_data), .m_axis_tstrb(big_strb), .m_axis_tuser(big_user),
    .m_axis_tvalid(big_valid), .m_axis_tready(m_tready), .m_axis_tlast(big_last),
    .pkt_count(big_pkt), .drop_count(big_drop)
  );

  nf10_crypto_pkt_buffer #(.C_DEPTH_BITS(4)) u_small (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(sml_s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(sml_data), .m_axis_tstrb(sml_strb), .m_axis_tuser(sml_user),
    .m_axis_tvalid(sml_valid), .m_axis_tready(m_tready), .m_axis_tlast(sml_last),
    .pkt_count(sml_pkt), .drop_count(sml_drop)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // One clock: at the falling edge, score a beat that the next rising edge transfers.
  task automatic step();
    beat_t e;
    beat_t g;
    @(negedge clk);
    if (rst_n && mon_valid && m_tready) begin
      g = {mon_last, mon_user, mon_strb, mon_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %0h required no beat", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL beat: got %0h required %0h", g, e);
        end
      end
    end
    @(posedge clk);
    #1;
    if (toggle_mode) m_tready = ~m_tready;
  endtask

  task automatic drive(input beat_t b);
    {s_tlast, s_tuser, s_tstrb, s_tdata} = b;
    s_tvalid = 1'b1;
  endtask

  task automatic idle_inputs();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < 8; k++) b.data[k*32 +: 32] = $urandom;
    for (int k = 0; k < 4; k++) b.user[k*32 +: 32] = $urandom;
    b.strb = $urandom;
    b.last = 1'b0;
    return b;
  endfunction

  task automatic send_pkt(input int len, input bit keep);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat();
      b.last = (i == len - 1);
      drive(b);
      if (keep) exp_q.push_back(b);
      step();
    end
    idle_inputs();
  endtask

  task automatic drain();
    m_tready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check("drain_left", 256'(exp_q.size()), 256'd0);
    repeat (4) step();
    check("drain_idle_valid", 256'(mon_valid), 256'd0);
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s_tready"}, 256'(mon_s_tready), 256'd0);
    check({tag, "_valid"}, 256'(mon_valid), 256'd0);
    check({tag, "_last"}, 256'(mon_last), 256'd0);
    check({tag, "_data"}, mon_data, 256'd0);
    check({tag, "_strb"}, 256'(mon_strb), 256'd0);
    check({tag, "_user"}, 256'(mon_user), 256'd0);
    check({tag, "_pkt"}, 256'(mon_pkt), 256'd0);
    check({tag, "_drop"}, 256'(mon_drop), 256'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_tready = 1'b0;
    toggle_mode = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    beat_t b;
    scen_t sc;
    tbl[0] = '{len1: 20, gap: 3, len2: 4, keep1: 1'b0, keep2: 1'b1, exp_pkt: 1, exp_drop: 1};
    tbl[1] = '{len1: 12, gap: 0, len2: 8, keep1: 1'b1, keep2: 1'b0, exp_pkt: 1, exp_drop: 1};
    tbl[2] = '{len1: 16, gap: 0, len2: 0, keep1: 1'b1, keep2: 1'b0, exp_pkt: 1, exp_drop: 0};
    tbl[3] = '{len1: 16, gap: 0, len2: 1, keep1: 1'b1, keep2: 1'b0, exp_pkt: 1, exp_drop: 1};
    tbl[4] = '{len1: 15, gap: 2, len2: 1, keep1: 1'b1, keep2: 1'b1, exp_pkt: 2, exp_drop: 0};

    // Reset state and tready rising on the first edge after release.
    use_small = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    check("tready_before_edge", 256'(mon_s_tready), 256'd0);
    step();
    check("tready_after_edge", 256'(mon_s_tready), 256'd1);

    // Single 3-beat packet, latency to first output beat.
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b = rand_beat();
      b.data = 256'(i + 1);
      b.last = (i == 2);
      drive(b);
      exp_q.push_back(b);
      step();
    end
    idle_inputs();
    check("lat_edge_n_valid", 256'(mon_valid), 256'd0);
    step();
    check("lat_edge_n1_valid", 256'(mon_valid), 256'd1);
    check("lat_edge_n1_data", mon_data, 256'd1);
    drain();
    check("p1_pkt", 256'(mon_pkt), 256'd1);

    // Ten back-to-back 4-beat packets with ready toggling every cycle.
    do_reset();
    m_tready = 1'b1;
    toggle_mode = 1'b1;
    for (int p = 0; p < 10; p++) send_pkt(4, 1'b1);
    toggle_mode = 1'b0;
    drain();
    check("b2b_pkt", 256'(mon_pkt), 256'd10);
    check("b2b_drop", 256'(mon_drop), 256'd0);

    // Overflow scenarios on the 16-deep instance, ready held low while sending.
    use_small = 1'b1;
    for (int t = 0; t < 5; t++) begin
      sc = tbl[t];
      do_reset();
      send_pkt(sc.len1, sc.keep1);
      repeat (sc.gap) step();
      if (sc.gap > 0) check($sformatf("scen%0d_gap_valid", t), 256'(mon_valid), 256'(sc.keep1));
      if (sc.len2 > 0) send_pkt(sc.len2, sc.keep2);
      drain();
      check($sformatf("scen%0d_pkt", t), 256'(mon_pkt), 256'(sc.exp_pkt));
      check($sformatf("scen%0d_drop", t), 256'(mon_drop), 256'(sc.exp_drop));
    end

    // Reset in the middle of a packet while a committed beat waits at the output.
    use_small = 1'b0;
    do_reset();
    send_pkt(1, 1'b0);
    step();
    check("pre_rst_valid", 256'(mon_valid), 256'd1);
    check("pre_rst_pkt", 256'(mon_pkt), 256'd1);
    for (int i = 0; i < 2; i++) begin
      b = rand_beat();
      drive(b);
      step();
    end
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send_pkt(2, 1'b1);
    drain();
    check("post_rst_pkt", 256'(mon_pkt), 256'd1);
    check("post_rst_drop", 256'(mon_drop), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
